// File: rtl/sseg_scan_decoder.sv
// Receive-side decoder for a multiplexed four-digit seven-segment bus: waits for each
// anode slot to settle, decodes it, and publishes complete frames with a one-cycle pulse.
//
// state  | meaning
// IDLE   | anode bus not one-hot-low, nothing to sample
// SETTLE | valid slot seen, counting consecutive identical samples
// HELD   | slot accepted, waiting for the bus to change
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp_on,
  output logic       frame_valid,
  output logic       seg_error,
  output logic       scan_lost
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  logic [11:0] sync1, smp, smp_prev;
  logic [3:0]  smp_an;
  logic        smp_dp;
  logic [6:0]  smp_seg;
  logic        an_valid, changed;
  logic [1:0]  slot;
  logic [3:0]  code;
  logic        code_bad;

  state_t      state, state_next;
  logic [SW-1:0] cnt, cnt_next;
  logic        accept;

  logic [3:0][3:0] shadow_code, merged_code;
  logic [3:0]      shadow_dp, merged_dp;
  logic [3:0]      mask, mask_acc;
  logic [TW-1:0]   tcnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= '0;
      smp      <= '0;
      smp_prev <= '0;
    end else begin
      sync1    <= {an, dp, g, f, e, d, c, b, a};
      smp      <= sync1;
      smp_prev <= smp;
    end
  end

  assign smp_an  = smp[11:8];
  assign smp_dp  = smp[7];
  assign smp_seg = smp[6:0];
  assign changed = (smp != smp_prev);

  always_comb begin
    an_valid = 1'b1;
    slot     = 2'd0;
    case (smp_an)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  // Segment lines are active-low, ordered {g,f,e,d,c,b,a}.
  always_comb begin
    code     = 4'hE;
    code_bad = 1'b0;
    case (smp_seg)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0111111: code = 4'hA;
      7'b1111111: code = 4'hF;
      default:    code_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (an_valid) begin
          state_next = S_SETTLE;
          cnt_next   = SW'(1);
        end
      end
      S_SETTLE: begin
        if (changed) begin
          state_next = an_valid ? S_SETTLE : S_IDLE;
          cnt_next   = an_valid ? SW'(1) : '0;
        end else if (cnt == SW'(STABLE_CYCLES - 1)) begin
          state_next = S_HELD;
          cnt_next   = SW'(STABLE_CYCLES);
        end else begin
          cnt_next = cnt + SW'(1);
        end
      end
      S_HELD: begin
        if (changed) begin
          state_next = an_valid ? S_SETTLE : S_IDLE;
          cnt_next   = an_valid ? SW'(1) : '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Accept fires on the cycle the STABLE_CYCLES-th identical sample is present.
  always_comb begin
    accept = (state == S_SETTLE) && !changed && (cnt == SW'(STABLE_CYCLES - 1));
  end

  always_comb begin
    merged_code = shadow_code;
    merged_dp   = shadow_dp;
    mask_acc    = mask;
    if (accept) begin
      merged_code[slot] = code;
      merged_dp[slot]   = ~smp_dp;
      mask_acc[slot]    = 1'b1;
    end
  end

  // The completing accept is merged straight into the published frame so the
  // outputs and pulse appear one cycle after it.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_code <= {4{4'hF}};
      shadow_dp   <= '0;
      mask        <= '0;
      digit0      <= 4'hF;
      digit1      <= 4'hF;
      digit2      <= 4'hF;
      digit3      <= 4'hF;
      dp_on       <= '0;
      frame_valid <= 1'b0;
      seg_error   <= 1'b0;
      tcnt        <= '0;
    end else begin
      frame_valid <= 1'b0;
      shadow_code <= merged_code;
      shadow_dp   <= merged_dp;
      if (mask_acc == 4'hF) begin
        digit0      <= merged_code[0];
        digit1      <= merged_code[1];
        digit2      <= merged_code[2];
        digit3      <= merged_code[3];
        dp_on       <= merged_dp;
        frame_valid <= 1'b1;
        mask        <= '0;
      end else begin
        mask <= mask_acc;
      end
      if (accept && code_bad) seg_error <= 1'b1;
      if (accept)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYCLES))
        tcnt <= tcnt + TW'(1);
    end
  end

  assign scan_lost = (tcnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: expected frames are queued when a scan is driven
// and compared when frame_valid pulses; status flags are checked inline.
module tb_sseg_scan_decoder;

  localparam int S = 16;
  localparam int T = 100;

  logic       clock, reset;
  logic       a, b, c, d, e, f, g, dp;
  logic [3:0] an;
  logic [3:0] digit0, digit1, digit2, digit3, dp_on;
  logic       frame_valid, seg_error, scan_lost;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dps;
  } frame_t;

  frame_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  int frames_seen = 0;

  sseg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dp_on(dp_on), .frame_valid(frame_valid), .seg_error(seg_error), .scan_lost(scan_lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Active-low {g..a}; code E stands for a deliberately unrecognised pattern.
  function automatic logic [6:0] pat(input logic [3:0] code);
    case (code)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0111111;
      4'hF: return 7'b1111111;
      default: return 7'b1010101;
    endcase
  endfunction

  task automatic set_bus(input logic [3:0] an_v, input logic [6:0] segs, input logic dp_v);
    an = an_v;
    {g, f, e, d, c, b, a} = segs;
    dp = dp_v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_slot(input int slot, input logic [3:0] code, input logic dp_lit, input int n);
    logic [3:0] one;
    one = 4'b0001 << slot;
    set_bus(~one, pat(code), ~dp_lit);
    hold(n);
  endtask

  task automatic go_idle(input int n);
    set_bus(4'hF, 7'h7F, 1'b1);
    hold(n);
  endtask

  task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] d3, input logic [3:0] dps);
    frame_t fr;
    fr.digits = {d3, d2, d1, d0};
    fr.dps    = dps;
    sb.push_back(fr);
  endtask

  always @(negedge clock) begin
    if (!reset && frame_valid) begin
      frame_t fr;
      frames_seen++;
      check("frame_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        fr = sb.pop_front();
        check("frame_digits", {16'h0, digit3, digit2, digit1, digit0}, {16'h0, fr.digits});
        check("frame_dp_on", {28'h0, dp_on}, {28'h0, fr.dps});
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs;
    int rise;
    reset = 1'b1;
    set_bus(4'hF, 7'h7F, 1'b1);
    hold(3);
    check("rst_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'hFFFF);
    check("rst_dp_on", {28'h0, dp_on}, 0);
    check("rst_frame_valid", {31'h0, frame_valid}, 0);
    check("rst_seg_error", {31'h0, seg_error}, 0);
    check("rst_scan_lost", {31'h0, scan_lost}, 0);
    reset = 1'b0;

    // Two repeated scans of 7,3,5,1 with dp on slots 1 and 3.
    for (int r = 0; r < 2; r++) begin
      push_frame(4'h7, 4'h3, 4'h5, 4'h1, 4'b1010);
      drive_slot(0, 4'h7, 1'b0, 64);
      drive_slot(1, 4'h3, 1'b1, 64);
      drive_slot(2, 4'h5, 1'b0, 64);
      drive_slot(3, 4'h1, 1'b1, 64);
    end
    go_idle(30);
    check("scan_frame_count", frames_seen, 2);
    check("scan_sb_drained", sb.size(), 0);
    check("scan_no_seg_error", {31'h0, seg_error}, 0);
    check("scan_outputs_hold", {16'h0, digit3, digit2, digit1, digit0}, 32'h1537);

    // Slot 2 held S-1 cycles must not be accepted.
    fs = frames_seen;
    drive_slot(0, 4'h2, 1'b0, 64);
    drive_slot(1, 4'h4, 1'b0, 64);
    drive_slot(2, 4'h6, 1'b0, S - 1);
    drive_slot(3, 4'h8, 1'b0, 64);
    check("short_slot_no_frame", frames_seen, fs);
    push_frame(4'h2, 4'h4, 4'h6, 4'h8, 4'b0000);
    drive_slot(2, 4'h6, 1'b0, 64);
    go_idle(30);
    check("short_slot_redrive_frame", frames_seen, fs + 1);
    check("short_slot_sb_drained", sb.size(), 0);

    // Dash is legal; an unknown pattern sets the sticky error.
    fs = frames_seen;
    push_frame(4'hA, 4'h0, 4'hE, 4'h9, 4'b0000);
    drive_slot(0, 4'hA, 1'b0, 64);
    check("dash_no_error", {31'h0, seg_error}, 0);
    drive_slot(1, 4'h0, 1'b0, 64);
    drive_slot(2, 4'hE, 1'b0, 64);
    check("bad_pattern_error", {31'h0, seg_error}, 1);
    drive_slot(3, 4'h9, 1'b0, 64);
    go_idle(30);
    push_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b0001);
    drive_slot(0, 4'h1, 1'b1, 64);
    drive_slot(1, 4'h2, 1'b0, 64);
    drive_slot(2, 4'h3, 1'b0, 64);
    drive_slot(3, 4'h4, 1'b0, 64);
    go_idle(30);
    check("seg_error_sticky", {31'h0, seg_error}, 1);
    check("error_frames_count", frames_seen, fs + 2);

    // Idle and multi-low anode gaps between slots.
    fs = frames_seen;
    push_frame(4'h9, 4'h8, 4'h7, 4'h6, 4'b0100);
    drive_slot(0, 4'h9, 1'b0, 64);
    set_bus(4'hF, pat(4'h8), 1'b1);
    hold(200);
    drive_slot(1, 4'h8, 1'b0, 64);
    drive_slot(2, 4'h7, 1'b1, 64);
    set_bus(4'b1100, pat(4'h3), 1'b0);
    hold(200);
    check("gap_no_frame_yet", frames_seen, fs);
    drive_slot(3, 4'h6, 1'b0, 64);
    go_idle(30);
    check("gap_frame_count", frames_seen, fs + 1);
    check("gap_sb_drained", sb.size(), 0);

    // Timeout: scan_lost rises T cycles after the accept edge.
    drive_slot(0, 4'h5, 1'b0, 0);
    rise = 0;
    for (int n = 1; n <= 400 && rise == 0; n++) begin
      @(negedge clock);
      if (n == 64) set_bus(4'hF, 7'h7F, 1'b1);
      if (n == S + 2) check("scan_lost_after_accept", {31'h0, scan_lost}, 0);
      if (n > S + 2 && scan_lost) rise = n;
    end
    check("scan_lost_rise_cycle", rise, S + 2 + T);
    drive_slot(1, 4'h5, 1'b0, 0);
    for (int n = 1; n <= S + 2; n++) begin
      @(negedge clock);
      if (n == S + 1) check("scan_lost_before_accept", {31'h0, scan_lost}, 1);
      if (n == S + 2) check("scan_lost_cleared", {31'h0, scan_lost}, 0);
    end
    hold(40);

    // Reset mid-frame: slots 0 and 1 are already in the shadow.
    fs = frames_seen;
    set_bus(4'hF, 7'h7F, 1'b1);
    reset = 1'b1;
    hold(2);
    reset = 1'b0;
    check("midrst_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'hFFFF);
    check("midrst_dp_on", {28'h0, dp_on}, 0);
    check("midrst_seg_error", {31'h0, seg_error}, 0);
    check("midrst_scan_lost", {31'h0, scan_lost}, 0);
    push_frame(4'h6, 4'h7, 4'h8, 4'h9, 4'b0010);
    drive_slot(3, 4'h9, 1'b0, 64);
    drive_slot(2, 4'h8, 1'b0, 64);
    drive_slot(1, 4'h7, 1'b1, 64);
    drive_slot(0, 4'h6, 1'b0, 64);
    go_idle(30);
    check("post_reset_one_frame", frames_seen, fs + 1);
    check("post_reset_sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
